// File: rtl/cnn_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cnn_seq_pkg                                                     |
// | Purpose  : Shared state encoding and default geometry for the CNN layer    |
// |            sequencer and its result-buffer drain engine.                   |
// | Contents : seq_state_e - sequencer / drain state encoding                  |
// |            C_*         - default stage count, buffer depth, data width,    |
// |                          read latency and done timeout                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package cnn_seq_pkg;

  localparam int C_NUM_STAGES  = 4;
  localparam int C_OUT_DEPTH   = 2048;   // 4x4x128 last-stage activations
  localparam int C_DATA_W      = 4;
  localparam int C_RD_LAT      = 1;
  localparam int C_TIMEOUT_CYC = 2**20;
  localparam int C_ADDR_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_OUT      = 3'd5,
    ST_FINISH   = 3'd6,
    ST_ERROR    = 3'd7
  } seq_state_e;

endpackage : cnn_seq_pkg
`default_nettype wire

// File: rtl/cnn_buf_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cnn_buf_drain                                                   |
// | Purpose  : Walks the last-stage output buffer from word 0 to OUT_DEPTH-1,  |
// |            issuing one read, waiting RD_LAT cycles, then presenting the    |
// |            word on a valid/ready stream until it is accepted.              |
// | Ports    : clk, resetn   - clock / async active-low reset                  |
// |            go            - one-cycle request to drain from word 0          |
// |            finished      - one-cycle pulse as the final word is accepted   |
// |            rd_addr       - buffer read address (holds when not reading)    |
// |            rd_data       - buffer read data, valid RD_LAT after rd_addr    |
// |            out_data/out_valid/out_last/out_ready - result stream           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cnn_buf_drain
  import cnn_seq_pkg::*;
#(
  parameter int OUT_DEPTH = C_OUT_DEPTH,
  parameter int DATA_W    = C_DATA_W,
  parameter int RD_LAT    = C_RD_LAT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     go,
  output logic                     finished,
  output logic [C_ADDR_W-1:0]      rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready
);

  localparam int C_IDX_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int C_LAT_W = $clog2(RD_LAT + 1);
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(OUT_DEPTH - 1);
  localparam logic [C_LAT_W-1:0] C_LAT_END  = C_LAT_W'(RD_LAT);

  seq_state_e               r_phase, w_phase_nxt;
  logic [C_IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [C_LAT_W-1:0]       r_lat, w_lat_nxt;
  logic [C_ADDR_W-1:0]      r_rd_addr, w_rd_addr_nxt;
  logic signed [DATA_W-1:0] r_out_data, w_out_data_nxt;
  logic                     w_is_last;

  // Terminal word found by compare; the index never wraps.
  assign w_is_last = (r_idx == C_LAST_IDX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_phase    <= ST_IDLE;
      r_idx      <= '0;
      r_lat      <= '0;
      r_rd_addr  <= '0;
      r_out_data <= '0;
    end else begin
      r_phase    <= w_phase_nxt;
      r_idx      <= w_idx_nxt;
      r_lat      <= w_lat_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_out_data <= w_out_data_nxt;
    end
  end

  always_comb begin
    w_phase_nxt    = r_phase;
    w_idx_nxt      = r_idx;
    w_lat_nxt      = r_lat;
    w_rd_addr_nxt  = r_rd_addr;
    w_out_data_nxt = r_out_data;
    finished       = 1'b0;
    unique case (r_phase)
      ST_IDLE: begin
        if (go) begin
          w_idx_nxt     = '0;
          w_rd_addr_nxt = '0;
          w_phase_nxt   = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        w_lat_nxt   = C_LAT_W'(1);
        w_phase_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // r_lat counts RD_WAIT cycles from 1; data is valid in the last one.
        if (r_lat == C_LAT_END) begin
          w_out_data_nxt = rd_data;
          w_phase_nxt    = ST_OUT;
        end else begin
          w_lat_nxt = r_lat + 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (w_is_last) begin
            finished    = 1'b1;
            w_phase_nxt = ST_IDLE;
          end else begin
            w_idx_nxt     = r_idx + 1'b1;
            // The address moves on the same edge the next read is issued.
            w_rd_addr_nxt = C_ADDR_W'(w_idx_nxt);
            w_phase_nxt   = ST_RD_ISSUE;
          end
        end
      end
      default: w_phase_nxt = ST_IDLE;
    endcase
  end

  assign rd_addr   = r_rd_addr;
  assign out_data  = r_out_data;
  assign out_valid = (r_phase == ST_OUT);
  assign out_last  = out_valid && w_is_last;

endmodule : cnn_buf_drain
`default_nettype wire

// File: rtl/cnn_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cnn_layer_sequencer                                             |
// | Purpose  : Starts NUM_STAGES chained layer engines in index order, waits   |
// |            for a fresh done edge from each, then drains the last stage's   |
// |            result buffer as a valid/ready stream.                          |
// | Ports    : clk, resetn        - clock / async active-low reset             |
// |            run                - pulse to start an inference sequence       |
// |            stage_start/done   - per-stage start pulse / done level         |
// |            rd_addr/rd_data    - last-stage buffer read port                |
// |            out_data/out_valid/out_ready/out_last - result stream           |
// |            cur_stage          - running stage, NUM_STAGES while draining   |
// |            busy, done         - activity flag / end-of-sequence pulse      |
// |            timeout_err        - sticky stage-done timeout flag             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int NUM_STAGES  = C_NUM_STAGES,
  parameter int OUT_DEPTH   = C_OUT_DEPTH,
  parameter int DATA_W      = C_DATA_W,
  parameter int RD_LAT      = C_RD_LAT,
  parameter int TIMEOUT_CYC = C_TIMEOUT_CYC
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            run,
  output logic [NUM_STAGES-1:0]           stage_start,
  input  logic [NUM_STAGES-1:0]           stage_done,
  output logic [C_ADDR_W-1:0]             rd_addr,
  input  logic signed [DATA_W-1:0]        rd_data,
  output logic signed [DATA_W-1:0]        out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [$clog2(NUM_STAGES):0]     cur_stage,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout_err
);

  localparam int C_CUR_W = $clog2(NUM_STAGES) + 1;
  localparam int C_TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [C_CUR_W-1:0] C_LAST_STAGE = C_CUR_W'(NUM_STAGES - 1);
  localparam logic [C_CUR_W-1:0] C_DRAINING   = C_CUR_W'(NUM_STAGES);
  // Count value one below the terminal: the increment on this edge would
  // make the counter reach TIMEOUT_CYC-1, so the timeout is taken here.
  localparam logic [C_TMO_W-1:0] C_TMO_PRE    = C_TMO_W'(TIMEOUT_CYC - 2);

  seq_state_e            r_state, w_state_nxt;
  logic [C_CUR_W-1:0]    r_cur, w_cur_nxt;
  logic [C_TMO_W-1:0]    r_tmo_cnt, w_tmo_cnt_nxt;
  logic                  r_tmo_err, w_tmo_err_nxt;
  logic [NUM_STAGES-1:0] r_done_q;
  logic [NUM_STAGES-1:0] w_cur_onehot;
  logic [NUM_STAGES-1:0] w_edges;
  logic                  w_done_edge;
  logic                  w_tmo_hit;
  logic                  w_drain_go;
  logic                  w_drain_finished;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_sel
    assign w_cur_onehot[gi] = (r_cur == C_CUR_W'(gi));
  end

  // A done that is already high when its stage starts is left over from an
  // earlier run; only a fresh low-to-high transition counts, and only on the
  // stage currently being run.
  assign w_edges     = stage_done & ~r_done_q;
  assign w_done_edge = |(w_edges & w_cur_onehot);
  assign w_tmo_hit   = (r_tmo_cnt == C_TMO_PRE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_cur     <= '0;
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
      r_done_q  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur     <= w_cur_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_tmo_err <= w_tmo_err_nxt;
      r_done_q  <= stage_done;
    end
  end

  // During the drain the top FSM parks in ST_RD_ISSUE; the drain engine
  // sequences the RD_ISSUE/RD_WAIT/OUT steps itself and reports completion.
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_nxt     = r_cur;
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_tmo_err_nxt = r_tmo_err;
    w_drain_go    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_tmo_err_nxt = 1'b0;
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        w_tmo_cnt_nxt = '0;
        w_state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        // A done edge takes priority over a simultaneous timeout.
        if (w_done_edge) begin
          if (r_cur == C_LAST_STAGE) begin
            w_cur_nxt   = C_DRAINING;
            w_drain_go  = 1'b1;
            w_state_nxt = ST_RD_ISSUE;
          end else begin
            w_cur_nxt   = r_cur + 1'b1;
            w_state_nxt = ST_START;
          end
        end else if (w_tmo_hit) begin
          w_tmo_err_nxt = 1'b1;
          w_state_nxt   = ST_ERROR;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        end
      end
      ST_RD_ISSUE, ST_RD_WAIT, ST_OUT: begin
        if (w_drain_finished) begin
          w_state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_cur_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      ST_ERROR: begin
        if (run) begin
          w_tmo_err_nxt = 1'b0;
          w_cur_nxt     = '0;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  cnn_buf_drain #(
    .OUT_DEPTH (OUT_DEPTH),
    .DATA_W    (DATA_W),
    .RD_LAT    (RD_LAT)
  ) u_drain (
    .clk       (clk),
    .resetn    (resetn),
    .go        (w_drain_go),
    .finished  (w_drain_finished),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  assign stage_start = (r_state == ST_START) ? w_cur_onehot : '0;
  assign cur_stage   = r_cur;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_ERROR);
  assign done        = (r_state == ST_FINISH);
  assign timeout_err = r_tmo_err;

endmodule : cnn_layer_sequencer
`default_nettype wire

// File: tb/tb_cnn_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cnn_layer_sequencer                                          |
// | Purpose  : Directed self-checking bench for cnn_layer_sequencer: nominal   |
// |            run, stale done levels, backpressure, stage timeout, reset      |
// |            mid-drain, and ignored run / foreign done edges.                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cnn_layer_sequencer;

  localparam int NS        = 4;
  localparam int DEPTH     = 2048;
  localparam int DW        = 4;
  localparam int RL        = 1;
  localparam int TMO       = 64;
  localparam int STAGE_DLY = 40;
  // Start-to-start spacing: done rises STAGE_DLY cycles after the start
  // cycle, the edge is taken that cycle, and the next START follows.
  localparam int SPACING   = STAGE_DLY + 2;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 run = 1'b0;
  logic [NS-1:0]        stage_start;
  logic [NS-1:0]        stage_done;
  logic [31:0]          rd_addr;
  logic signed [DW-1:0] rd_data = '0;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_last;
  logic [2:0]           cur_stage;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;

  cnn_layer_sequencer #(
    .NUM_STAGES (NS), .OUT_DEPTH (DEPTH), .DATA_W (DW),
    .RD_LAT (RL), .TIMEOUT_CYC (TMO)
  ) dut (
    .clk (clk), .resetn (resetn), .run (run),
    .stage_start (stage_start), .stage_done (stage_done),
    .rd_addr (rd_addr), .rd_data (rd_data),
    .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
    .out_last (out_last), .cur_stage (cur_stage), .busy (busy),
    .done (done), .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural stage engines and result buffer -------------
  logic [NS-1:0] model_done = '0;
  logic [NS-1:0] armed = '0;
  logic [NS-1:0] never_mask = '0;
  logic [NS-1:0] suppress = '0;
  int            dly [NS];

  assign stage_done = model_done & ~suppress;

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (stage_start[i]) begin
        model_done[i] <= 1'b0;
        armed[i]      <= 1'b1;
        dly[i]        <= STAGE_DLY;
      end else if (armed[i]) begin
        if (dly[i] == 1) begin
          armed[i] <= 1'b0;
          if (!never_mask[i]) model_done[i] <= 1'b1;
        end
        dly[i] <= dly[i] - 1;
      end
    end
  end

  // Buffer content: value = address mod 16, registered read (RD_LAT = 1).
  always @(posedge clk) rd_data <= rd_addr[DW-1:0];

  bit bp = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  // ---------------- stream / control monitor --------------------------------
  int          scen_id = 0;
  int          seen_id = 0;
  int          cyc = 0;
  int          starts, bad_onehot, words, data_err, last_err, stall_err;
  int          rate_err, dones, last_acc;
  int          start_order[$];
  int          start_cyc[$];
  int          cur_trace[$];
  logic [2:0]  prev_cur = '0;
  bit          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (scen_id != seen_id) begin
      seen_id = scen_id;
      starts = 0; bad_onehot = 0; words = 0; data_err = 0; last_err = 0;
      stall_err = 0; rate_err = 0; dones = 0; last_acc = 0;
      start_order.delete(); start_cyc.delete(); cur_trace.delete();
    end
    if (!resetn) begin
      prev_stall = 1'b0;
      prev_cur   = '0;
    end else begin
      if (stage_start != '0) begin
        starts++;
        if ($countones(stage_start) != 1) bad_onehot++;
        for (int i = 0; i < NS; i++) if (stage_start[i]) start_order.push_back(i);
        start_cyc.push_back(cyc);
      end
      if (cur_stage != prev_cur) begin
        cur_trace.push_back(int'(cur_stage));
        prev_cur = cur_stage;
      end
      if (done) dones++;
      if (prev_stall && (!out_valid || $unsigned(out_data) !== prev_data ||
                         out_last !== prev_last)) stall_err++;
      if (out_valid && out_ready) begin
        if ($unsigned(out_data) !== DW'(words)) data_err++;
        if (out_last !== (words == DEPTH - 1)) last_err++;
        if (!bp && words > 0 && (cyc - last_acc) != RL + 2) rate_err++;
        last_acc = cyc;
        words++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = $unsigned(out_data);
      prev_last  = out_last;
    end
  end

  // ---------------- checking helpers ----------------------------------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(input int s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (stage_start[s]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_run(input string p);
    check({p, "_starts"}, starts, NS);
    check({p, "_onehot"}, bad_onehot, 0);
    for (int i = 0; i < NS; i++)
      check($sformatf("%s_order%0d", p, i), start_order.size() > i ? start_order[i] : -1, i);
    for (int i = 0; i + 1 < NS; i++)
      check($sformatf("%s_spacing%0d", p, i),
            start_cyc.size() > i + 1 ? start_cyc[i+1] - start_cyc[i] : -1, SPACING);
    check({p, "_trace_len"}, cur_trace.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_trace%0d", p, i), cur_trace.size() > i ? cur_trace[i] : -1, (i + 1) % 5);
    check({p, "_words"}, words, DEPTH);
    check({p, "_data_err"}, data_err, 0);
    check({p, "_last_err"}, last_err, 0);
    check({p, "_rate_err"}, rate_err, 0);
    check({p, "_done_cnt"}, dones, 1);
    check({p, "_busy_end"}, busy, 0);
    check({p, "_cur_end"}, cur_stage, 0);
  endtask

  task automatic check_outputs_zero(input string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_valid"}, out_valid, 0);
    check({p, "_data"}, out_data, 0);
    check({p, "_last"}, out_last, 0);
    check({p, "_rd_addr"}, rd_addr, 0);
    check({p, "_start"}, stage_start, 0);
    check({p, "_cur"}, cur_stage, 0);
    check({p, "_done"}, done, 0);
    check({p, "_tmo"}, timeout_err, 0);
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    bit ok;
    int n;

    #12;
    check_outputs_zero("reset");
    @(negedge clk); resetn = 1'b1;
    repeat (3) @(negedge clk);

    // 1: nominal run
    scen_id++;
    pulse_run();
    wait_done(20000, ok);
    check("s1_done_seen", ok, 1);
    check_run("s1");

    // 2: every stage_done still high from the previous run
    scen_id++;
    check("s2_stale_levels", stage_done, 4'hF);
    pulse_run();
    wait_done(20000, ok);
    check("s2_done_seen", ok, 1);
    check_run("s2");

    // 3: backpressure, out_ready ~30% high
    bp = 1'b1;
    scen_id++;
    pulse_run();
    wait_done(60000, ok);
    check("s3_done_seen", ok, 1);
    check("s3_words", words, DEPTH);
    check("s3_data_err", data_err, 0);
    check("s3_last_err", last_err, 0);
    check("s3_stall_err", stall_err, 0);
    check("s3_done_cnt", dones, 1);
    bp = 1'b0;

    // 4: stage 2 never signals done
    never_mask = 4'b0100;
    scen_id++;
    pulse_run();
    wait_start(2, 2000, ok);
    check("s4_start2_seen", ok, 1);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      n++;
      if (timeout_err) break;
    end
    check("s4_tmo_cycles", n, TMO);
    check("s4_tmo_err", timeout_err, 1);
    check("s4_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("s4_tmo_sticky", timeout_err, 1);
    check("s4_no_drain", words, 0);
    never_mask = '0;
    pulse_run();
    @(negedge clk);
    check("s4_tmo_cleared", timeout_err, 0);
    check("s4_idle_busy", busy, 0);
    scen_id++;
    pulse_run();
    wait_done(20000, ok);
    check("s4_rerun_done", ok, 1);
    check("s4_rerun_words", words, DEPTH);
    check("s4_rerun_data", data_err, 0);
    check("s4_rerun_tmo", timeout_err, 0);

    // 5: reset in the middle of the drain
    scen_id++;
    pulse_run();
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk);
      if (words >= 700) begin ok = 1'b1; break; end
    end
    check("s5_reach_700", ok, 1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check_outputs_zero("s5_async");
    @(negedge clk); resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("s5_idle_after", busy, 0);
    scen_id++;
    pulse_run();
    wait_done(20000, ok);
    check("s5_rerun_done", ok, 1);
    check("s5_rerun_words", words, DEPTH);
    check("s5_rerun_data", data_err, 0);
    check("s5_rerun_last", last_err, 0);

    // 6: run while busy and done edges on non-current stages
    scen_id++;
    pulse_run();
    repeat (10) @(negedge clk);
    suppress = 4'b1110;
    repeat (2) @(negedge clk);
    suppress = '0;
    repeat (3) @(negedge clk);
    run = 1'b1;
    @(negedge clk); run = 1'b0;
    wait_start(2, 2000, ok);
    check("s6_start2_seen", ok, 1);
    repeat (10) @(negedge clk);
    suppress = 4'b1001;
    repeat (2) @(negedge clk);
    suppress = '0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    check("s6_drain_seen", ok, 1);
    run = 1'b1;
    @(negedge clk); run = 1'b0;
    wait_done(20000, ok);
    check("s6_done_seen", ok, 1);
    check_run("s6");
    repeat (20) @(negedge clk);
    check("s6_no_restart", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cnn_layer_sequencer
`default_nettype wire
